// File: rtl/i2s_pkg.sv
// Types and default sizes shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_SLOT_W = 32;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] left;
        logic [DEF_DATA_W-1:0] right;
    } sample_pair_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: registered bck plus one-clk strobes marking the clk in which bck toggles.
module i2s_bck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic bck,
    output logic bck_rise,
    output logic bck_fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bck_q, bck_d;
    logic          tc;

    assign tc = (cnt_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        bck_d    = bck_q;
        bck_rise = 1'b0;
        bck_fall = 1'b0;
        if (!en) begin
            cnt_d = RELOAD;
            bck_d = 1'b0;
        end else if (tc) begin
            cnt_d    = RELOAD;
            bck_d    = ~bck_q;
            bck_rise = ~bck_q;
            bck_fall = bck_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= RELOAD;
            bck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bck_q <= bck_d;
        end
    end

    assign bck = bck_q;

endmodule

// File: rtl/i2s_xmtr.sv
// I2S master transmitter: holding register, frame sequencer and MSB-first serialiser.
// state | meaning
// IDLE  | bck/lrck/data held low, divider and position cleared; waits for enable
// RUN   | frames running; leaves only at a frame boundary once enable is low
module i2s_xmtr
    import i2s_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SLOT_W  = DEF_SLOT_W,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bck,
    output logic              lrck,
    output logic              data,
    output logic              underrun
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int PW         = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] P_LAST  = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] P_SLOT  = PW'(SLOT_W);
    localparam logic [PW-1:0] P_LDATA = PW'(DATA_W);
    localparam logic [PW-1:0] P_RDATA = PW'(SLOT_W + DATA_W);

    state_t                state_q, state_d;
    logic [PW-1:0]         pos_q, pos_d, pos_nx;
    logic                  lrck_q, lrck_d;
    logic                  data_q, data_d;
    logic                  underrun_q, underrun_d;
    logic                  hold_full_q, hold_full_d;
    logic [2*DATA_W-1:0]   hold_q, hold_d;
    logic [2*DATA_W-1:0]   shift_q, shift_d;

    logic run_en, bck_fall, bck_rise_unused;
    logic wrap, frame_start, hs, xfer;

    assign run_en = (state_q == RUN);

    i2s_bck_gen #(.CLK_DIV(CLK_DIV)) u_bck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (run_en),
        .bck      (bck),
        .bck_rise (bck_rise_unused),
        .bck_fall (bck_fall)
    );

    // A frame boundary is the falling bck that would start position 0.
    assign wrap        = run_en && bck_fall && (pos_q == P_LAST);
    assign frame_start = enable && ((state_q == IDLE) || wrap);
    assign hs          = s_valid && !hold_full_q;
    assign xfer        = frame_start && hold_full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (wrap && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pos_d       = pos_q;
        pos_nx      = pos_q + 1'b1;
        lrck_d      = lrck_q;
        data_d      = data_q;
        shift_d     = shift_q;
        underrun_d  = frame_start && !hold_full_q;
        hold_d      = hs ? {s_left, s_right} : hold_q;
        hold_full_d = (hold_full_q && !xfer) || hs;

        if (frame_start) begin
            pos_d   = '0;
            lrck_d  = 1'b0;
            data_d  = 1'b0;
            shift_d = hold_full_q ? hold_q : '0;
        end else if (run_en && bck_fall) begin
            if (pos_q == P_LAST) begin
                pos_d  = '0;
                lrck_d = 1'b0;
                data_d = 1'b0;
            end else begin
                pos_d  = pos_nx;
                lrck_d = (pos_nx >= P_SLOT);
                // Left bits follow the p=0 delay slot, right bits the p=SLOT_W one.
                if ((pos_nx <= P_LDATA) || ((pos_nx > P_SLOT) && (pos_nx <= P_RDATA))) begin
                    data_d  = shift_q[2*DATA_W-1];
                    shift_d = shift_q << 1;
                end else begin
                    data_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q       <= '0;
            lrck_q      <= 1'b0;
            data_q      <= 1'b0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            shift_q     <= '0;
        end else begin
            pos_q       <= pos_d;
            lrck_q      <= lrck_d;
            data_q      <= data_d;
            underrun_q  <= underrun_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
        end
    end

    assign lrck     = lrck_q;
    assign data     = data_q;
    assign underrun = underrun_q;
    assign s_ready  = !hold_full_q;

endmodule
